mdu_ctrl: RTL and testbench

Multiply/divide unit with sequencing control for the E stage of the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and owns the architectural HI/LO registers. For a fixed multi-cycle latency it emits start and busy, which the hazard unit uses to stall mul/div-class instructions in D. Exception/interrupt requests suppress issue so that an instruction flushed by CP0 never alters HI/LO.

---
 rtl/mdu_ctrl_pkg.sv | 30 +++
 rtl/mdu_arith.sv | 65 ++++++
 rtl/mdu_ctrl.sv | 107 ++++++++++
 tb/tb_mdu_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, FSM states and widths for the multiply/divide unit.
package mdu_ctrl_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 2 * DATA_W;

  localparam logic [OP_W-1:0] MDU_NONE  = 3'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 3'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 3'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 3'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 3'd4;
  localparam logic [OP_W-1:0] MDU_MTHI  = 3'd5;
  localparam logic [OP_W-1:0] MDU_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Multiply-class ops, which use the shorter busy sequence.
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing a {hi,lo} result and a divide-by-zero flag.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] res,
  output logic        div0
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic [63:0]        a_zx;
  logic [63:0]        b_zx;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        uq;
  logic [31:0]        ur;

  assign a_sx = $signed({{32{A[31]}}, A});
  assign b_sx = $signed({{32{B[31]}}, B});
  assign a_zx = {32'h0, A};
  assign b_zx = {32'h0, B};
  assign a_s  = $signed(A);
  assign b_s  = $signed(B);

  always_comb begin
    res  = '0;
    div0 = 1'b0;
    sq   = '0;
    sr   = '0;
    uq   = '0;
    ur   = '0;
    case (op)
      MDU_MULT:  res = 64'(a_sx * b_sx);
      MDU_MULTU: res = a_zx * b_zx;
      MDU_DIV: begin
        if (B == 32'h0) begin
          div0 = 1'b1;
        // The only signed quotient that overflows; pin it to the MIPS result.
        end else if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
          res = {32'h0, 32'h8000_0000};
        end else begin
          sq  = a_s / b_s;
          sr  = a_s % b_s;
          res = {sr, sq};
        end
      end
      MDU_DIVU: begin
        if (B == 32'h0) begin
          div0 = 1'b1;
        end else begin
          uq  = A / B;
          ur  = A % B;
          res = {ur, uq};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer for the E stage: owns HI/LO, issues mul/div, and holds busy for a fixed latency.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic        op_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [63:0]        res_q;
  logic [63:0]        res_d;
  logic               div0_q;
  logic               div0_d;
  logic [31:0]        hi_d;
  logic [31:0]        lo_d;
  logic               issue;
  logic [63:0]        arith_res;
  logic               arith_div0;

  mdu_arith u_arith (
    .op   (op),
    .A    (A),
    .B    (B),
    .res  (arith_res),
    .div0 (arith_div0)
  );

  assign issue = op_valid && (state_q == IDLE) && !req;

  // State, counter, latched result and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      div0_q  <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      div0_q  <= div0_d;
      busy    <= (state_d == BUSY);
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

  // Next-state, issue and commit logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    div0_d  = div0_q;
    hi_d    = hi;
    lo_d    = lo;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          if (is_mul(op) || is_div(op)) begin
            start   = 1'b1;
            state_d = BUSY;
            cnt_d   = is_mul(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            res_d   = arith_res;
            div0_d  = arith_div0;
          end else if (op == MDU_MTHI) begin
            hi_d = A;
          end else if (op == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          // Divide by zero runs the full sequence but leaves HI/LO untouched.
          if (!div0_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl against an arithmetic HI/LO model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int unsigned N_MULT = 5;
  localparam int unsigned N_DIV  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  op;
  logic        op_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu_ctrl #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .op_valid (op_valid),
    .A        (A),
    .B        (B),
    .req      (req),
    .start    (start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result: {div0, hi, lo}, from the architectural definitions.
  function automatic logic [64:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (o)
      MDU_MULT: begin
        sp = longint'(sa) * longint'(sb);
        return {1'b0, 64'(sp)};
      end
      MDU_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        return {1'b0, up};
      end
      MDU_DIV: begin
        if (b == 32'h0) return {1'b1, 64'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
      MDU_DIVU: begin
        if (b == 32'h0) return {1'b1, 64'h0};
        return {1'b0, a % b, a / b};
      end
      default: return {1'b1, 64'h0};
    endcase
  endfunction

  // Present one op for a cycle, then walk the whole busy window (if any) checking each cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input bit intrude);
    bit          is_md;
    int unsigned n;
    logic [64:0] m;
    is_md = (o == MDU_MULT || o == MDU_MULTU || o == MDU_DIV || o == MDU_DIVU);
    n     = (o == MDU_MULT || o == MDU_MULTU) ? N_MULT : N_DIV;
    @(negedge clk);
    op = o; A = a; B = b; req = r; op_valid = 1'b1;
    #1;
    chk("start", 64'(start), 64'(is_md && !r));
    @(negedge clk);
    op_valid = 1'b0; req = 1'b0; op = MDU_NONE;
    if (is_md && !r) begin
      for (int i = 1; i <= int'(n); i++) begin
        chk("busy_hi", 64'(busy), 64'h1);
        chk("hold_hi", 64'(hi), 64'(hi_m));
        if (intrude && i == 2) begin
          op_valid = 1'b1; op = MDU_MTHI; A = 32'h0000_ABCD;
          #1;
          chk("start_busy", 64'(start), 64'h0);
        end
        // Keep req asserted at times to show it cannot cancel an in-flight op.
        req = (i == 3);
        @(negedge clk);
        op_valid = 1'b0; op = MDU_NONE; req = 1'b0;
      end
      m = ref_md(o, a, b);
      if (!m[64]) begin
        hi_m = m[63:32];
        lo_m = m[31:0];
      end
    end else if (!r && o == MDU_MTHI) begin
      hi_m = a;
    end else if (!r && o == MDU_MTLO) begin
      lo_m = a;
    end
    chk("busy_lo", 64'(busy), 64'h0);
    chk("hi", 64'(hi), 64'(hi_m));
    chk("lo", 64'(lo), 64'(lo_m));
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rr;
    reset = 1'b0; op = MDU_NONE; op_valid = 1'b0; A = '0; B = '0; req = 1'b0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_start", 64'(start), 64'h0);
    reset = 1'b1;

    do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("tp_mult", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("tp_multu", {32'(hi), 32'(lo)}, 64'h0000_0001_FFFF_FFFE);
    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("tp_div", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFD);

    do_op(MDU_MTHI, 32'h11, 32'h0, 1'b0, 1'b0);
    do_op(MDU_MTLO, 32'h22, 32'h0, 1'b0, 1'b0);
    do_op(MDU_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
    chk("tp_div0", {32'(hi), 32'(lo)}, 64'h0000_0011_0000_0022);

    do_op(MDU_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
    do_op(MDU_MTLO, 32'h5, 32'h0, 1'b1, 1'b0);
    chk("tp_req_lo", 64'(lo), 64'h22);

    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("tp_ovf", {32'(hi), 32'(lo)}, 64'h0000_0000_8000_0000);

    do_op(MDU_MULT, 32'h1234, 32'h10, 1'b0, 1'b1);
    do_op(MDU_MTHI, 32'h77, 32'h0, 1'b0, 1'b0);
    chk("tp_mthi_after", 64'(hi), 64'h77);

    // Reset in the third busy cycle discards the in-flight product.
    @(negedge clk);
    op = MDU_MULT; A = 32'd9; B = 32'd9; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; op = MDU_NONE;
    repeat (2) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hi_m = '0; lo_m = '0;
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_hilo", {32'(hi), 32'(lo)}, 64'h0);
    repeat (8) @(negedge clk);
    chk("no_late_commit", {32'(hi), 32'(lo)}, 64'h0);
    chk("no_late_busy", 64'(busy), 64'h0);

    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      rr = ($urandom_range(0, 7) == 0);
      do_op(ro, ra, rb, rr, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
